// File: rtl/dii_insn_gen.sv
// dii_insn_gen: generator end of the DII link.
// The host pushes an instruction sequence into a FIFO. The FIFO head is shown to
// the core's DII fetch ports, and one entry is popped per ack. Once the last
// instruction has been injected, the block waits for RVFI retirement to catch up
// (or for an idle timeout) and then reports done.
// Ports:
//   clk_i, rst_ni                    clock; asynchronous active-high reset
//   host_valid_i/insn_i/last_i       host push request, instruction, end-of-sequence flag
//   host_ready_o                     push accepted when valid & ready (combinational)
//   start_i                          IDLE->RUN, DONE->IDLE (clear)
//   dii_insn_0_o/1_o                 instruction presented to the core (combinational)
//   dii_ack_0_i/1_i, dii_pc_i        core consumed the presented instruction, and its PC
//   rvfi_valid_i                     core retired an instruction
//   busy_o, done_o, timeout_o        run status
//   ack_err_o                        sticky: both acks seen in one cycle
//   inj_cnt_o/ret_cnt_o/nop_cnt_o    injected / retired / NOP-fill counters
//   last_pc_o                        PC captured at the last real injection
module dii_insn_gen #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter logic [31:0] NOP_INSN      = 32'h13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             host_valid_i,
    input  logic [31:0]      host_insn_i,
    input  logic             host_last_i,
    output logic             host_ready_o,
    input  logic             start_i,
    output logic [31:0]      dii_insn_0_o,
    output logic [31:0]      dii_insn_1_o,
    input  logic             dii_ack_0_i,
    input  logic             dii_ack_1_i,
    input  logic [31:0]      dii_pc_i,
    input  logic             rvfi_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             ack_err_o,
    output logic [CNT_W-1:0] inj_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o,
    output logic [CNT_W-1:0] nop_cnt_o,
    output logic [31:0]      last_pc_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [31:0]      mem_insn_q [DEPTH];
    logic [DEPTH-1:0] mem_last_q;
    logic             seq_closed_q, ack_err_q, timeout_q;
    logic [CNT_W-1:0] inj_cnt_q, ret_cnt_q, nop_cnt_q;
    logic [31:0]      last_pc_q;
    logic [IW-1:0]    idle_q;

    logic             empty, full, push, pop, ack, dual_ack, head_last;
    logic [31:0]      head_insn;
    logic [CNT_W-1:0] ret_inc;

    // Occupancy decode: the extra pointer bit separates full from empty
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_insn = mem_insn_q[rd_ptr_q[AW-1:0]];
    assign head_last = mem_last_q[rd_ptr_q[AW-1:0]];

    assign host_ready_o = !full && !seq_closed_q && (state_q != S_DONE);
    assign push         = host_valid_i && host_ready_o;
    assign ack          = dii_ack_0_i || dii_ack_1_i;
    assign dual_ack     = dii_ack_0_i && dii_ack_1_i;
    assign pop          = (state_q == S_RUN) && ack && !empty;
    // DRAIN exit compares against the count including this cycle's retirement
    assign ret_inc      = ret_cnt_q + CNT_W'(rvfi_valid_i);

    // Zero-latency presentation: the ack in a cycle consumes what is shown in it
    assign dii_insn_0_o = ((state_q == S_RUN) && !empty) ? head_insn : NOP_INSN;
    assign dii_insn_1_o = dii_insn_0_o;

    assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);
    assign timeout_o = timeout_q;
    assign ack_err_o = ack_err_q;
    assign inj_cnt_o = inj_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
    assign nop_cnt_o = nop_cnt_q;
    assign last_pc_o = last_pc_q;

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_insn_q[wr_ptr_q[AW-1:0]] <= host_insn_i;
            mem_last_q[wr_ptr_q[AW-1:0]] <= host_last_i;
        end
    end

    // Sequencer, FIFO pointers, counters and flags
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            seq_closed_q <= 1'b0;
            ack_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            inj_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            nop_cnt_q    <= '0;
            last_pc_q    <= '0;
            idle_q       <= '0;
        end else begin
            if (dual_ack) ack_err_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (host_last_i) seq_closed_q <= 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (rvfi_valid_i && busy_o) ret_cnt_q <= ret_inc;

            case (state_q)
                S_IDLE: begin
                    if (start_i) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (ack) begin
                        if (!empty) begin
                            inj_cnt_q <= inj_cnt_q + CNT_W'(1);
                            last_pc_q <= dii_pc_i;
                            if (head_last) begin
                                state_q <= S_DRAIN;
                                idle_q  <= '0;
                            end
                        end else begin
                            nop_cnt_q <= nop_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (ret_inc == inj_cnt_q) begin
                        state_q <= S_DONE;
                    end else if (rvfi_valid_i) begin
                        idle_q <= '0;
                    end else if (idle_q == IW'(DRAIN_TIMEOUT - 1)) begin
                        state_q   <= S_DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                S_DONE: begin
                    // Clear takes priority over a dual ack seen in the same cycle
                    if (start_i) begin
                        state_q      <= S_IDLE;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        seq_closed_q <= 1'b0;
                        ack_err_q    <= 1'b0;
                        timeout_q    <= 1'b0;
                        inj_cnt_q    <= '0;
                        ret_cnt_q    <= '0;
                        nop_cnt_q    <= '0;
                        last_pc_q    <= '0;
                        idle_q       <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dii_insn_gen.sv
module tb_dii_insn_gen;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO   = 64;
    localparam logic [31:0] NOP   = 32'h13;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic clk, rst_ni;
    logic host_valid, host_last, host_ready, start;
    logic [31:0] host_insn, insn0, insn1, pc;
    logic ack0, ack1, rvfi, busy, done, tmo, aerr;
    logic [CNT_W-1:0] inj, ret, nop;
    logic [31:0] last_pc;

    dii_insn_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DRAIN_TIMEOUT(TMO), .NOP_INSN(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_valid_i(host_valid), .host_insn_i(host_insn), .host_last_i(host_last),
        .host_ready_o(host_ready), .start_i(start),
        .dii_insn_0_o(insn0), .dii_insn_1_o(insn1),
        .dii_ack_0_i(ack0), .dii_ack_1_i(ack1), .dii_pc_i(pc),
        .rvfi_valid_i(rvfi), .busy_o(busy), .done_o(done), .timeout_o(tmo),
        .ack_err_o(aerr), .inj_cnt_o(inj), .ret_cnt_o(ret), .nop_cnt_o(nop),
        .last_pc_o(last_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;

    // Reference model: sequence-level state of the generator
    bit [32:0] mq [$];
    int        m_state;
    bit        m_closed, m_err, m_tmo;
    bit [15:0] m_inj, m_ret, m_nop;
    bit [31:0] m_pc;
    int        m_idle;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = M_IDLE; m_closed = 0; m_err = 0; m_tmo = 0;
        m_inj = 0; m_ret = 0; m_nop = 0; m_pc = 0; m_idle = 0;
    endtask

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && !m_closed && (m_state != M_DONE);
    endfunction

    function automatic logic [31:0] m_head();
        return (m_state == M_RUN && mq.size() > 0) ? mq[0][31:0] : NOP;
    endfunction

    task automatic check_status();
        cmp("busy",    32'(busy),       32'(m_state == M_RUN || m_state == M_DRAIN));
        cmp("done",    32'(done),       32'(m_state == M_DONE));
        cmp("timeout", 32'(tmo),        32'(m_tmo));
        cmp("ack_err", 32'(aerr),       32'(m_err));
        cmp("ready",   32'(host_ready), 32'(m_ready()));
        cmp("insn0",   insn0,           m_head());
        cmp("insn1",   insn1,           m_head());
        cmp("inj_cnt", 32'(inj),        32'(m_inj));
        cmp("ret_cnt", 32'(ret),        32'(m_ret));
        cmp("nop_cnt", 32'(nop),        32'(m_nop));
        cmp("last_pc", last_pc,         m_pc);
    endtask

    // One clock cycle: drive inputs, queue the expected ack response, advance the model
    task automatic step(input bit hv, input logic [31:0] hi, input bit hl, input bit st,
                        input bit a0, input bit a1, input logic [31:0] p, input bit rv);
        bit acc;
        bit [32:0] e;
        host_valid = hv; host_insn = hi; host_last = hl; start = st;
        ack0 = a0; ack1 = a1; pc = p; rvfi = rv;
        acc = hv && m_ready();
        if (a0 || a1) sb.push_back(m_head());
        if (a0 && a1) m_err = 1;
        case (m_state)
            M_IDLE: if (st) m_state = M_RUN;
            M_RUN: begin
                if (rv) m_ret++;
                if (a0 || a1) begin
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        m_inj++;
                        m_pc = p;
                        if (e[32]) begin m_state = M_DRAIN; m_idle = 0; end
                    end else begin
                        m_nop++;
                    end
                end
            end
            M_DRAIN: begin
                if (rv) begin m_ret++; m_idle = 0; end
                else m_idle++;
                if (m_ret == m_inj) m_state = M_DONE;
                else if (m_idle >= TMO) begin m_state = M_DONE; m_tmo = 1; end
            end
            default: if (st) model_reset();
        endcase
        if (acc) begin
            mq.push_back({hl, hi});
            if (hl) m_closed = 1;
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle1();                                  step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic push(input logic [31:0] i, input bit l);  step(1, i, l, 0, 0, 0, 0, 0); endtask
    task automatic go();                                     step(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic ackp(input logic [31:0] p, input bit rv); step(0, 0, 0, 0, 1, 0, p, rv); endtask
    task automatic retire();                                 step(0, 0, 0, 0, 0, 0, 0, 1); endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, model state %0d", name, m_state);
    endtask

    // Monitor: every ack must consume the value the scoreboard predicted
    always @(negedge clk) begin
        if (!rst_ni && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                bound_fail("sb_underflow");
            end else begin
                mon_exp = sb.pop_front();
                cmp("ack_insn0", insn0, mon_exp);
                cmp("ack_insn1", insn1, mon_exp);
            end
        end
    end

    task automatic random_seq(input int id);
        int k, n;
        bit hl, rv;
        k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) push($urandom, 0);
        go();
        n = 0;
        while (m_state != M_DONE && n < 1000) begin
            hl = (n > 40) || ($urandom_range(0, 7) == 0);
            if (m_state == M_DRAIN) rv = (m_ret < m_inj) && ($urandom_range(0, 2) == 0);
            else rv = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 1), $urandom, hl, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom, rv);
            n++;
        end
        if (m_state != M_DONE) bound_fail($sformatf("rand_seq%0d", id));
        go();
    endtask

    initial begin
        int n;
        rst_ni = 1'b1;
        host_valid = 0; host_insn = 0; host_last = 0; start = 0;
        ack0 = 0; ack1 = 0; pc = 0; rvfi = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        cmp("rst_insn", insn0, NOP);
        cmp("rst_ready", 32'(host_ready), 32'd1);
        check_status();

        // Preload three, run with an ack every cycle, then retire three
        push(32'hA0000001, 0); push(32'hA0000002, 0); push(32'hA0000003, 1);
        go();
        for (int i = 0; i < 5; i++) ackp(32'h1000 + 32'(4 * i), 0);
        cmp("t1_inj", 32'(inj), 32'd3);
        cmp("t1_drain", 32'(busy), 32'd1);
        cmp("t1_last_pc", last_pc, 32'h1008);
        repeat (3) retire();
        cmp("t1_done", 32'(done), 32'd1);
        cmp("t1_tmo", 32'(tmo), 32'd0);
        cmp("t1_ret", 32'(ret), 32'd3);
        go();

        // Start empty: NOP fills, then a late push appears the cycle after
        go();
        ackp(32'h2000, 0); ackp(32'h2004, 0);
        push(32'h00100093, 1);
        cmp("t2_head", insn0, 32'h00100093);
        ackp(32'h2008, 0);
        cmp("t2_nop", 32'(nop), 32'd2);
        cmp("t2_inj", 32'(inj), 32'd1);
        retire();
        cmp("t2_done", 32'(done), 32'd1);
        go();

        // Fill to DEPTH, push+ack together keeps occupancy at DEPTH-1
        for (int i = 0; i < DEPTH; i++) push($urandom, 0);
        cmp("t3_full_ready", 32'(host_ready), 32'd0);
        go();
        ackp(32'h3000, 0);
        cmp("t3_ready_after_pop", 32'(host_ready), 32'd1);
        step(1, 32'hBEEF0001, 0, 0, 1, 0, 32'h3004, 0);
        cmp("t3_ready_pushpop", 32'(host_ready), 32'd1);
        push(32'hBEEF0002, 0);
        cmp("t3_full_again", 32'(host_ready), 32'd0);
        ackp(32'h3008, 0);
        push(32'hBEEF0003, 1);
        n = 0;
        while (m_state == M_RUN && n < 100) begin ackp(32'h3100 + 32'(n), 0); n++; end
        if (m_state != M_DRAIN) bound_fail("t3_drain");
        cmp("t3_inj", 32'(inj), 32'(DEPTH + 3));
        n = 0;
        while (m_state != M_DONE && n < 100) begin retire(); n++; end
        if (m_state != M_DONE) bound_fail("t3_done");
        go();

        // Four injected, three retired: exit through the idle timeout
        for (int i = 0; i < 4; i++) push(32'hC0000000 + 32'(i), i == 3);
        go();
        for (int i = 0; i < 4; i++) ackp(32'h4000 + 32'(4 * i), i < 3);
        n = 0;
        while (!done && n < TMO + 10) begin idle1(); n++; end
        cmp("t4_idle_cycles", 32'(n), 32'(TMO));
        cmp("t4_tmo", 32'(tmo), 32'd1);
        cmp("t4_ret", 32'(ret), 32'd3);
        cmp("t4_inj", 32'(inj), 32'd4);
        go();

        // Dual ack: one pop, sticky error, cleared by start in DONE
        push(32'hD0000001, 0); push(32'hD0000002, 1);
        go();
        step(0, 0, 0, 0, 1, 1, 32'h5000, 0);
        cmp("t5_inj", 32'(inj), 32'd1);
        cmp("t5_err", 32'(aerr), 32'd1);
        cmp("t5_head", insn0, 32'hD0000002);
        ackp(32'h5004, 0);
        retire(); retire();
        cmp("t5_err_sticky", 32'(aerr), 32'd1);
        go();
        cmp("t5_clr_err", 32'(aerr), 32'd0);
        cmp("t5_clr_inj", 32'(inj), 32'd0);
        cmp("t5_clr_ret", 32'(ret), 32'd0);
        cmp("t5_clr_pc", last_pc, 32'd0);
        cmp("t5_clr_done", 32'(done), 32'd0);

        // Randomised sequences
        for (int s = 0; s < 8; s++) random_seq(s);

        // Asynchronous reset mid-run with five entries queued
        for (int i = 0; i < 7; i++) push(32'hE0000000 + 32'(i), 0);
        go();
        ackp(32'h6000, 0); ackp(32'h6004, 0);
        #1 rst_ni = 1'b1;
        #1;
        model_reset();
        cmp("t7_insn", insn0, NOP);
        cmp("t7_ready", 32'(host_ready), 32'd1);
        cmp("t7_inj", 32'(inj), 32'd0);
        cmp("t7_busy", 32'(busy), 32'd0);
        check_status();
        @(posedge clk);
        #1 rst_ni = 1'b0;
        push(32'hF0000001, 1);
        go();
        cmp("t7_fresh_head", insn0, 32'hF0000001);
        ackp(32'h7000, 0);
        retire();
        cmp("t7_done", 32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
